uart_tx_arb: RTL and testbench

- Shares the single UART transmit character path between three requesters: CPU-written output characters, RX echo-back characters and a monitor/debug character source.
- CPU and echo sources are one-shot pulse interfaces, each buffered by its own small FIFO. The monitor source uses a valid/ready handshake.
- Sits between the IO-bus UART output register logic and the UART transmitter. It drives the transmitter's write strobe and character, and returns per-source full status.

---
 rtl/uart_tx_arb.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Shares the single UART transmit character path between three sources:
//   CPU output characters and RX echo-back characters (pulse interfaces,
//   each buffered in its own FIFO) and a monitor/debug source (valid/ready).
//   A round-robin arbiter (CPU -> echo -> monitor) issues at most one
//   character every two cycles, leaving the transmitter's full flag a cycle
//   to update after each write strobe.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cpu_we/cpu_char       CPU push strobe and character
//   cpu_full              CPU FIFO holds FIFO_DEPTH entries
//   echo_we/echo_char     echo push strobe and character
//   echo_full             echo FIFO holds FIFO_DEPTH entries
//   mon_valid/mon_char    monitor character offer (held until mon_ready)
//   mon_ready             one-cycle accept pulse for the monitor character
//   tx_we/tx_char         write strobe and character to the transmitter
//   tx_full               transmitter cannot accept a character
//   ovf_clr               clears both sticky overflow flags
//   ovf_flags             sticky drop flags: [0]=CPU, [1]=echo
//   busy                  work pending or a write strobe in flight
module uart_tx_arb #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_we,
    input  logic [7:0] cpu_char,
    output logic       cpu_full,
    input  logic       echo_we,
    input  logic [7:0] echo_char,
    output logic       echo_full,
    input  logic       mon_valid,
    input  logic [7:0] mon_char,
    output logic       mon_ready,
    output logic       tx_we,
    output logic [7:0] tx_char,
    input  logic       tx_full,
    input  logic       ovf_clr,
    output logic [1:0] ovf_flags,
    output logic       busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SRC_CPU  = 2'd0,
        SRC_ECHO = 2'd1,
        SRC_MON  = 2'd2
    } src_e;

    // Index 0 = CPU FIFO, index 1 = echo FIFO
    logic [7:0]      mem_q  [2][FIFO_DEPTH];
    logic [PW-1:0]   wptr_q [2];
    logic [PW-1:0]   rptr_q [2];
    logic [CW-1:0]   cnt_q  [2];
    logic [1:0][7:0] push_char;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      accept;
    logic [2:0]      elig;

    src_e       last_q;
    src_e       gnt;
    logic       gnt_vld;
    logic [7:0] gnt_char;
    logic       tx_we_q;
    logic [7:0] tx_char_q;
    logic       mon_ready_q;
    logic [1:0] ovf_q;

    assign push      = {echo_we, cpu_we};
    assign push_char = {echo_char, cpu_char};
    assign elig      = {mon_valid, (cnt_q[1] != '0), (cnt_q[0] != '0)};

    // Round-robin search starting one past the last grant; the cycle with
    // tx_we high is always skipped so tx_full can reflect the new character.
    always_comb begin
        logic [2:0] s;
        gnt_vld = 1'b0;
        gnt     = SRC_CPU;
        s       = '0;
        if (!tx_full && !tx_we_q) begin
            for (int unsigned k = 1; k <= 3; k++) begin
                s = {1'b0, last_q} + 3'(k);
                if (s >= 3'd3) begin
                    s = s - 3'd3;
                end
                if (!gnt_vld && elig[s[1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt     = src_e'(s[1:0]);
                end
            end
        end
    end

    always_comb begin
        pop[0]    = gnt_vld && (gnt == SRC_CPU);
        pop[1]    = gnt_vld && (gnt == SRC_ECHO);
        // A full FIFO still takes a push when it is popped in the same cycle
        accept[0] = push[0] && ((cnt_q[0] != DEPTH_C) || pop[0]);
        accept[1] = push[1] && ((cnt_q[1] != DEPTH_C) || pop[1]);
    end

    always_comb begin
        case (gnt)
            SRC_CPU:  gnt_char = mem_q[0][rptr_q[0]];
            SRC_ECHO: gnt_char = mem_q[1][rptr_q[1]];
            default:  gnt_char = mon_char;
        endcase
    end

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        always_ff @(posedge clk) begin
            if (accept[i]) begin
                mem_q[i][wptr_q[i]] <= push_char[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end else begin
                if (accept[i]) begin
                    wptr_q[i] <= wptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + 1'b1;
                end
                case ({accept[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
                    2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= SRC_MON;
            tx_we_q     <= 1'b0;
            tx_char_q   <= '0;
            mon_ready_q <= 1'b0;
            ovf_q       <= '0;
        end else begin
            tx_we_q     <= gnt_vld;
            mon_ready_q <= gnt_vld && (gnt == SRC_MON);
            if (gnt_vld) begin
                tx_char_q <= gnt_char;
                last_q    <= gnt;
            end
            if (ovf_clr) begin
                ovf_q <= '0;
            end else begin
                ovf_q <= ovf_q | (push & ~accept);
            end
        end
    end

    assign cpu_full  = (cnt_q[0] == DEPTH_C);
    assign echo_full = (cnt_q[1] == DEPTH_C);
    assign tx_we     = tx_we_q;
    assign tx_char   = tx_char_q;
    assign mon_ready = mon_ready_q;
    assign ovf_flags = ovf_q;
    assign busy      = (cnt_q[0] != '0) || (cnt_q[1] != '0) || mon_valid || tx_we_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: queue-based reference model, directed scenario
// tasks and a randomized run, all compared cycle by cycle.
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_char = '0;
    logic       cpu_full;
    logic       echo_we = 1'b0;
    logic [7:0] echo_char = '0;
    logic       echo_full;
    logic       mon_valid = 1'b0;
    logic [7:0] mon_char = '0;
    logic       mon_ready;
    logic       tx_we;
    logic [7:0] tx_char;
    logic       tx_full = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [1:0] ovf_flags;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_we(cpu_we), .cpu_char(cpu_char), .cpu_full(cpu_full),
        .echo_we(echo_we), .echo_char(echo_char), .echo_full(echo_full),
        .mon_valid(mon_valid), .mon_char(mon_char), .mon_ready(mon_ready),
        .tx_we(tx_we), .tx_char(tx_char), .tx_full(tx_full),
        .ovf_clr(ovf_clr), .ovf_flags(ovf_flags), .busy(busy)
    );

    // ---------------- reference model ----------------
    logic [7:0] cq[$];
    logic [7:0] eq[$];
    int         m_last;
    bit         m_txwe;
    bit         m_monrdy;
    logic [7:0] m_txchar;
    logic [1:0] m_ovf;

    always @(posedge clk or negedge rst_n) begin : model
        int g;
        bit [2:0] el;
        bit cok, eok;
        logic [7:0] ch;
        if (!rst_n) begin
            cq.delete(); eq.delete();
            m_last = 2; m_txwe = 0; m_monrdy = 0; m_txchar = '0; m_ovf = '0;
        end else begin
            el = {mon_valid, eq.size() != 0, cq.size() != 0};
            g  = -1;
            ch = m_txchar;
            if (!tx_full && !m_txwe)
                for (int k = 1; k <= 3; k++)
                    if (g < 0 && el[(m_last + k) % 3]) g = (m_last + k) % 3;
            cok = cpu_we && (cq.size() < 4 || g == 0);
            eok = echo_we && (eq.size() < 4 || g == 1);
            if (g == 0) ch = cq.pop_front();
            else if (g == 1) ch = eq.pop_front();
            else if (g == 2) ch = mon_char;
            if (cok) cq.push_back(cpu_char);
            if (eok) eq.push_back(echo_char);
            if (ovf_clr) m_ovf = '0;
            else m_ovf = m_ovf | {echo_we && !eok, cpu_we && !cok};
            m_txwe   = (g >= 0);
            m_monrdy = (g == 2);
            if (g >= 0) begin
                m_txchar = ch;
                m_last   = g;
            end
        end
    end

    function automatic logic [14:0] model_vec();
        return {m_txwe, m_txchar, m_monrdy, cq.size() == 4, eq.size() == 4, m_ovf,
                (cq.size() != 0 || eq.size() != 0 || mon_valid || m_txwe)};
    endfunction

    logic [14:0] obs_vec;
    assign obs_vec = {tx_we, tx_char, mon_ready, cpu_full, echo_full, ovf_flags, busy};

    // Emitted-character log with the cycle each strobe was seen
    logic [7:0] got[$];
    int         got_cyc[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) if (rst_n && tx_we) begin
        got.push_back(tx_char);
        got_cyc.push_back(cyc);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; cpu_we = 0; echo_we = 0; mon_valid = 0; tx_full = 0; ovf_clr = 0;
        @(negedge clk);
        rst_n = 1;
        got.delete(); got_cyc.delete();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (obs_vec !== 15'h0) begin
            failures++; $display("FAIL reset_outputs: got=%h exp=%h", obs_vec, 15'h0);
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (obs_vec !== model_vec()) begin
            failures++; $display("FAIL reset_idle: got=%h exp=%h", obs_vec, model_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        cpu_we = 1; cpu_char = 8'h41;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL single_model c=%0d: got=%h exp=%h", c, obs_vec, model_vec());
            end
            if (c == 0) begin
                checks++;
                if (tx_we !== 1'b0) begin
                    failures++; $display("FAIL single_early: tx_we=%b exp=0", tx_we);
                end
            end
            if (c == 1) begin
                checks++;
                if ({tx_we, tx_char, cpu_full} !== {1'b1, 8'h41, 1'b0}) begin
                    failures++; $display("FAIL single_issue: we=%b char=%h full=%b exp 1/41/0", tx_we, tx_char, cpu_full);
                end
            end
            if (c == 2) begin
                checks++;
                if ({tx_we, busy} !== 2'b00) begin
                    failures++; $display("FAIL single_idle: we=%b busy=%b exp 0/0", tx_we, busy);
                end
            end
            cpu_we = 0;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tx_full = 1;
        for (int i = 0; i < 5; i++) begin
            cpu_we = 1; cpu_char = 8'(32'h30 + i);
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL ovf_fill i=%0d: got=%h exp=%h", i, obs_vec, model_vec());
            end
            if (i == 3) begin
                checks++;
                if (cpu_full !== 1'b1) begin
                    failures++; $display("FAIL ovf_full: cpu_full=%b exp=1", cpu_full);
                end
            end
            if (i == 4) begin
                checks++;
                if (ovf_flags !== 2'b01) begin
                    failures++; $display("FAIL ovf_flag: got=%b exp=01", ovf_flags);
                end
            end
        end
        cpu_we = 0; tx_full = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL ovf_drain c=%0d: got=%h exp=%h", c, obs_vec, model_vec());
            end
        end
        checks++;
        if (got.size() != 4) begin
            failures++; $display("FAIL ovf_count: got=%0d exp=4", got.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (got[j] !== 8'(32'h30 + j)) begin
                    failures++; $display("FAIL ovf_order j=%0d: got=%h exp=%h", j, got[j], 8'(32'h30 + j));
                end
            end
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (got_cyc[j+1] - got_cyc[j] != 2) begin
                    failures++; $display("FAIL ovf_gap j=%0d: got=%0d exp=2", j, got_cyc[j+1] - got_cyc[j]);
                end
            end
        end
        ovf_clr = 1;
        @(negedge clk);
        ovf_clr = 0;
        checks++;
        if (ovf_flags !== 2'b00) begin
            failures++; $display("FAIL ovf_clear: got=%b exp=00", ovf_flags);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_q[$];
        int mrdy;
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21};
        mrdy = 0;
        do_reset();
        tx_full = 1;
        cpu_we = 1; cpu_char = 8'h10; echo_we = 1; echo_char = 8'h20;
        @(negedge clk);
        cpu_char = 8'h11; echo_char = 8'h21;
        @(negedge clk);
        cpu_we = 0; echo_we = 0; mon_valid = 1; mon_char = 8'h30;
        @(negedge clk);
        tx_full = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL rr_model c=%0d: got=%h exp=%h", c, obs_vec, model_vec());
            end
            if (mon_ready) begin
                mrdy++;
                checks++;
                if ({tx_we, tx_char} !== {1'b1, 8'h30}) begin
                    failures++; $display("FAIL rr_monalign: we=%b char=%h exp 1/30", tx_we, tx_char);
                end
                mon_valid = 0;
            end
        end
        checks++;
        if (mrdy != 1) begin
            failures++; $display("FAIL rr_monpulses: got=%0d exp=1", mrdy);
        end
        checks++;
        if (got.size() != 5) begin
            failures++; $display("FAIL rr_count: got=%0d exp=5", got.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (got[j] !== exp_q[j]) begin
                    failures++; $display("FAIL rr_order j=%0d: got=%h exp=%h", j, got[j], exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        tx_full = 1;
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1; cpu_char = 8'(32'h50 + i);
            @(negedge clk);
        end
        checks++;
        if (cpu_full !== 1'b1) begin
            failures++; $display("FAIL fpp_full: cpu_full=%b exp=1", cpu_full);
        end
        tx_full = 0; cpu_char = 8'h54;
        @(negedge clk);
        cpu_we = 0;
        checks++;
        if ({cpu_full, ovf_flags, tx_we, tx_char} !== {1'b1, 2'b00, 1'b1, 8'h50}) begin
            failures++; $display("FAIL fpp_same_cycle: full=%b ovf=%b we=%b char=%h exp 1/00/1/50",
                                 cpu_full, ovf_flags, tx_we, tx_char);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL fpp_model c=%0d: got=%h exp=%h", c, obs_vec, model_vec());
            end
        end
        checks++;
        if (got.size() != 5) begin
            failures++; $display("FAIL fpp_count: got=%0d exp=5", got.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (got[j] !== 8'(32'h50 + j)) begin
                    failures++; $display("FAIL fpp_order j=%0d: got=%h exp=%h", j, got[j], 8'(32'h50 + j));
                end
            end
        end
    endtask

    task automatic test_txfull_toggle();
        int nxt, hold;
        bit full_prev;
        nxt = 0; hold = 0; full_prev = 0;
        do_reset();
        for (int c = 0; c < 90; c++) begin
            echo_we = (nxt < 8 && eq.size() < 4);
            echo_char = 8'(32'hA0 + nxt);
            if (echo_we) nxt++;
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL txf_model c=%0d: got=%h exp=%h", c, obs_vec, model_vec());
            end
            checks++;
            if (tx_we && full_prev) begin
                failures++; $display("FAIL txf_blocked c=%0d: tx_we=%b exp=0", c, tx_we);
            end
            if (tx_we) hold = 3;
            tx_full = (hold > 0);
            if (hold > 0) hold--;
            full_prev = tx_full;
        end
        echo_we = 0; tx_full = 0;
        checks++;
        if (got.size() != 8) begin
            failures++; $display("FAIL txf_count: got=%0d exp=8", got.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (got[j] !== 8'(32'hA0 + j)) begin
                    failures++; $display("FAIL txf_order j=%0d: got=%h exp=%h", j, got[j], 8'(32'hA0 + j));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        do_reset();
        tx_full = 1;
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1; cpu_char = 8'(32'h70 + i);
            @(negedge clk);
        end
        cpu_we = 0; tx_full = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            seen = tx_we;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL rmid_wait: tx_we never rose within 4 cycles");
        end
        rst_n = 0;
        #1;
        checks++;
        if (obs_vec !== 15'h0) begin
            failures++; $display("FAIL rmid_clear: got=%h exp=%h", obs_vec, 15'h0);
        end
        @(negedge clk);
        rst_n = 1;
        got.delete(); got_cyc.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({tx_we, busy} !== 2'b00) begin
                failures++; $display("FAIL rmid_quiet c=%0d: we=%b busy=%b exp 0/0", c, tx_we, busy);
            end
        end
        cpu_we = 1; cpu_char = 8'h77; echo_we = 1; echo_char = 8'h66;
        @(negedge clk);
        cpu_we = 0; echo_we = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL rmid_model c=%0d: got=%h exp=%h", c, obs_vec, model_vec());
            end
        end
        checks++;
        if (got.size() != 2 || got[0] !== 8'h77) begin
            failures++; $display("FAIL rmid_first: count=%0d first=%h exp 2/77", got.size(),
                                 (got.size() > 0) ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 700; c++) begin
            if (c < 660) begin
                cpu_we    = ($urandom_range(0, 2) == 0);
                cpu_char  = 8'($urandom);
                echo_we   = ($urandom_range(0, 2) == 0);
                echo_char = 8'($urandom);
                tx_full   = ($urandom_range(0, 3) == 0);
                ovf_clr   = ($urandom_range(0, 19) == 0);
                if (!mon_valid && $urandom_range(0, 3) == 0) begin
                    mon_valid = 1; mon_char = 8'($urandom);
                end
            end else begin
                cpu_we = 0; echo_we = 0; tx_full = 0; ovf_clr = 0;
            end
            @(negedge clk);
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++; $display("FAIL random c=%0d: got=%h exp=%h", c, obs_vec, model_vec());
            end
            if (mon_ready) mon_valid = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_full_pushpop();
        test_txfull_toggle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
